// File: rtl/acc_in_packer.sv
// acc_in_packer: packs a serial stream of signed samples into 4-wide vectors
// for the 3-neuron accelerator. An assembly buffer fills the next vector while
// the holding register presents the current one on a valid/ready handshake.
module acc_in_packer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] X1,
    output logic [DATA_W-1:0] X2,
    output logic [DATA_W-1:0] X3,
    output logic [DATA_W-1:0] X4,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_pad,
    output logic [CNT_W-1:0]  vec_cnt
);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               slot_q, slot_d;
    logic [3:0][DATA_W-1:0]   asm_q, asm_d;
    logic                     pad_pend_q, pad_pend_d;
    logic [3:0][DATA_W-1:0]   hold_q, hold_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_pad_q, out_pad_d;
    logic [CNT_W-1:0]         vec_cnt_q, vec_cnt_d;
    logic                     in_ready_q, in_ready_d;

    logic                     accept_s;
    logic                     handoff_s;
    logic                     hold_free_s;
    logic                     complete_s;
    logic [3:0][DATA_W-1:0]   vec_s;

    assign accept_s    = in_valid && in_ready_q;
    assign handoff_s   = out_valid_q && out_ready;
    // Holding register can take a vector if it is empty or is being emptied now.
    assign hold_free_s = !out_valid_q || out_ready;
    assign complete_s  = (slot_q == 2'd3) || in_last;

    // Assembly buffer with the incoming sample merged in and slots past it zeroed.
    always_comb begin
        vec_s = asm_q;
        for (int i = 0; i < 4; i++) begin
            if (2'(i) == slot_q) begin
                vec_s[i] = in_data;
            end else if (2'(i) > slot_q) begin
                vec_s[i] = {DATA_W{1'b0}};
            end else begin
                vec_s[i] = asm_q[i];
            end
        end
    end

    // Next-state logic for fill/pend sequencing, holding register and counter.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        asm_d       = asm_q;
        pad_pend_d  = pad_pend_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_pad_d   = out_pad_q;
        vec_cnt_d   = vec_cnt_q;

        if (handoff_s) begin
            out_valid_d = 1'b0;
            vec_cnt_d   = vec_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            vec_cnt_d   = vec_cnt_q;
        end

        case (state_q)
            ST_FILL: begin
                if (accept_s && complete_s) begin
                    slot_d = 2'd0;
                    if (hold_free_s) begin
                        hold_d      = vec_s;
                        out_valid_d = 1'b1;
                        out_pad_d   = (slot_q != 2'd3);
                        asm_d       = '0;
                    end else begin
                        asm_d      = vec_s;
                        pad_pend_d = (slot_q != 2'd3);
                        state_d    = ST_PEND;
                    end
                end else if (accept_s) begin
                    asm_d  = vec_s;
                    slot_d = slot_q + 2'd1;
                end else begin
                    slot_d = slot_q;
                end
            end
            ST_PEND: begin
                if (hold_free_s) begin
                    hold_d      = asm_q;
                    out_valid_d = 1'b1;
                    out_pad_d   = pad_pend_q;
                    asm_d       = '0;
                    slot_d      = 2'd0;
                    state_d     = ST_FILL;
                end else begin
                    state_d = ST_PEND;
                end
            end
            default: begin
                state_d = ST_FILL;
                slot_d  = 2'd0;
                asm_d   = '0;
            end
        endcase

        // Registered ready: depends only on the next state, never on live inputs.
        in_ready_d = (state_d == ST_FILL);
    end

    // State registers with immediate clear on reset.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q     <= ST_FILL;
            slot_q      <= 2'd0;
            asm_q       <= '0;
            pad_pend_q  <= 1'b0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_pad_q   <= 1'b0;
            vec_cnt_q   <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            asm_q       <= asm_d;
            pad_pend_q  <= pad_pend_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_pad_q   <= out_pad_d;
            vec_cnt_q   <= vec_cnt_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign X1        = hold_q[0];
    assign X2        = hold_q[1];
    assign X3        = hold_q[2];
    assign X4        = hold_q[3];
    assign out_valid = out_valid_q;
    assign out_pad   = out_pad_q;
    assign vec_cnt   = vec_cnt_q;

endmodule

// File: tb/tb_acc_in_packer.sv
// Bench for acc_in_packer: directed scenarios plus a long random run, all
// checked against a sample-queue reference model and a handoff scoreboard.
module tb_acc_in_packer;

    logic        clk;
    logic        arst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  X1, X2, X3, X4;
    logic        out_valid;
    logic        out_ready;
    logic        out_pad;
    logic [15:0] vec_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int n_acc  = 0;

    // Reference model state
    logic [7:0]  part_q[$];
    logic [32:0] exp_q[$];
    logic [15:0] exp_cnt = 16'd0;
    logic        stall_v = 1'b0;
    logic [33:0] saved_v = 34'd0;

    acc_in_packer #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .arst(arst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .X1(X1), .X2(X2), .X3(X3), .X4(X4),
        .out_valid(out_valid), .out_ready(out_ready), .out_pad(out_pad),
        .vec_cnt(vec_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    // Monitor at the falling edge: observe what the next rising edge will transfer.
    always @(negedge clk) begin
        if (!arst) begin
            stall_v = 1'b0;
        end else begin
            check("vec_cnt", 64'(vec_cnt), 64'(exp_cnt));
            if (stall_v) begin
                check("stable", 64'({X1, X2, X3, X4, out_pad, out_valid}), 64'(saved_v));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_handoff", 64'd1, 64'd0);
                end else begin
                    check("vector", 64'({X1, X2, X3, X4, out_pad}), 64'(exp_q.pop_front()));
                end
                exp_cnt = exp_cnt + 16'd1;
            end
            stall_v = out_valid && !out_ready;
            saved_v = {X1, X2, X3, X4, out_pad, out_valid};
            if (in_valid && in_ready) begin
                n_acc++;
                part_q.push_back(in_data);
                if (part_q.size() == 4 || in_last) begin
                    logic [32:0] e;
                    e = 33'd0;
                    for (int i = 0; i < part_q.size(); i++) e[32-8*i -: 8] = part_q[i];
                    e[0] = (part_q.size() < 4);
                    exp_q.push_back(e);
                    part_q.delete();
                end
            end
        end
    end

    task automatic do_reset();
        arst = 1'b0;
        #1;
        check("rst_X", 64'({X1, X2, X3, X4}), 64'd0);
        check("rst_valid_pad", 64'({out_valid, out_pad}), 64'd0);
        check("rst_vec_cnt", 64'(vec_cnt), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        part_q.delete();
        exp_q.delete();
        exp_cnt = 16'd0;
        @(posedge clk); #3;
        arst = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_rst", 64'(in_ready), 64'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int w;
        in_data = d; in_last = l; in_valid = 1'b1; w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    initial begin
        arst = 1'b1; in_data = 8'd0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        #2;
        do_reset();

        // Full vector with the consumer ready
        out_ready = 1'b1;
        send(8'sd10, 1'b0); send(-8'sd20, 1'b0); send(8'sd30, 1'b0); send(-8'sd40, 1'b0);
        check("t1_vec", 64'({out_valid, X1, X2, X3, X4, out_pad}),
              64'({1'b1, 8'h0A, 8'hEC, 8'h1E, 8'hD8, 1'b0}));
        @(posedge clk); #1;
        check("t1_cnt", 64'(vec_cnt), 64'd1);
        check("t1_valid_clr", 64'(out_valid), 64'd0);

        // Stall: one vector held, one pending
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        check("t2_pend_ready", 64'(in_ready), 64'd0);
        check("t2_hold", 64'({out_valid, X1, X4}), 64'({1'b1, 8'd1, 8'd4}));
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t2_second", 64'({out_valid, X1, X2, X3, X4}), 64'({1'b1, 8'd5, 8'd6, 8'd7, 8'd8}));
        @(posedge clk); #1;
        check("t2_drained", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));

        // Early close and extremes
        send(8'h80, 1'b0); send(8'h7F, 1'b1);
        check("t3_short", 64'({X1, X2, X3, X4, out_pad}), 64'({8'h80, 8'h7F, 8'h00, 8'h00, 1'b1}));
        send(8'sd1, 1'b0); send(8'sd2, 1'b0); send(8'sd3, 1'b0); send(8'sd4, 1'b1);
        check("t3_full_last", 64'({X1, X4, out_pad}), 64'({8'd1, 8'd4, 1'b0}));
        send(8'hC3, 1'b1);
        check("t3_single", 64'({X1, X2, X3, X4, out_pad}), 64'({8'hC3, 24'd0, 1'b1}));
        @(posedge clk); #1;

        // Reset mid-vector
        send(8'd9, 1'b0); send(8'd9, 1'b0);
        do_reset();
        send(8'd21, 1'b0); send(8'd22, 1'b0); send(8'd23, 1'b0); send(8'd24, 1'b0);
        check("t5_clean", 64'({X1, X2, X3, X4, out_pad}), 64'({8'd21, 8'd22, 8'd23, 8'd24, 1'b0}));
        @(posedge clk); #1;
        check("t5_cnt", 64'(vec_cnt), 64'd1);

        // Reset while pending
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(i + 40), 1'b0);
        check("t5_pend", 64'(in_ready), 64'd0);
        do_reset();
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_handoff", 64'({out_valid, vec_cnt}), 64'd0);

        // Random traffic
        n_acc = 0;
        for (int c = 0; c < 40000 && n_acc < 10000; c++) begin
            in_valid  = ($urandom_range(0, 7) != 0);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        check("rand_count", 64'(n_acc >= 10000), 64'd1);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rand_drain", 64'(exp_q.size()), 64'd0);

        // Counter wrap
        #1;
        force dut.vec_cnt_q = 16'hFFFF;
        exp_cnt = 16'hFFFF;
        #1;
        release dut.vec_cnt_q;
        send(8'h11, 1'b1);
        @(posedge clk); #1;
        check("wrap", 64'(vec_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
